// File: rtl/mem_read_arbiter.sv
// Two-requester arbiter for a single SDRAM read port: captures each side's read
// request, issues one transfer at a time downstream and steers the data stream.
module mem_read_arbiter #(
    parameter int ARB_MODE   = 0,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int WORD_BYTES = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  req0_control_go_i,
    input  logic [ADDR_WIDTH-1:0] req0_control_base_i,
    input  logic [ADDR_WIDTH-1:0] req0_control_length_i,
    output logic                  req0_control_done_o,
    input  logic                  req0_user_re_i,
    output logic [DATA_WIDTH-1:0] req0_user_data_o,
    output logic                  req0_user_available_o,

    input  logic                  req1_control_go_i,
    input  logic [ADDR_WIDTH-1:0] req1_control_base_i,
    input  logic [ADDR_WIDTH-1:0] req1_control_length_i,
    output logic                  req1_control_done_o,
    input  logic                  req1_user_re_i,
    output logic [DATA_WIDTH-1:0] req1_user_data_o,
    output logic                  req1_user_available_o,

    output logic                  mem_control_go_o,
    output logic [ADDR_WIDTH-1:0] mem_control_base_o,
    output logic [ADDR_WIDTH-1:0] mem_control_length_o,
    input  logic                  mem_control_done_i,
    output logic                  mem_user_re_o,
    input  logic [DATA_WIDTH-1:0] mem_user_data_i,
    input  logic                  mem_user_available_i,

    output logic [1:0]            grant_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_BUSY  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] WORD_BYTES_W = ADDR_WIDTH'(WORD_BYTES);

    logic [1:0]            go_in;
    logic [1:0]            re_in;
    logic [ADDR_WIDTH-1:0] base_in [2];
    logic [ADDR_WIDTH-1:0] len_in  [2];

    logic [1:0]            capture;
    logic [1:0]            issue_clr;
    logic [1:0]            done_out;
    logic [1:0]            avail_out;
    logic [DATA_WIDTH-1:0] data_out [2];

    logic [1:0]            state_q, state_d;
    logic [1:0]            pending_q, pending_d;
    logic                  rr_ptr_q, rr_ptr_d;
    logic [1:0]            grant_q, grant_d;
    logic [ADDR_WIDTH-1:0] word_cnt_q, word_cnt_d;
    logic [ADDR_WIDTH-1:0] expected_q, expected_d;
    logic                  done_seen_q, done_seen_d;
    logic [ADDR_WIDTH-1:0] base_q [2];
    logic [ADDR_WIDTH-1:0] len_q  [2];
    logic [ADDR_WIDTH-1:0] mem_base_q, mem_base_d;
    logic [ADDR_WIDTH-1:0] mem_len_q, mem_len_d;

    logic                  busy;
    logic                  pick;
    logic                  pop;
    logic                  done_now;
    logic [ADDR_WIDTH-1:0] cnt_next;

    assign go_in      = {req1_control_go_i, req0_control_go_i};
    assign re_in      = {req1_user_re_i, req0_user_re_i};
    assign base_in[0] = req0_control_base_i;
    assign base_in[1] = req1_control_base_i;
    assign len_in[0]  = req0_control_length_i;
    assign len_in[1]  = req1_control_length_i;

    assign busy = (state_q == ST_BUSY);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            // A go while already pending or while owning the port is a protocol violation and dropped.
            assign capture[gi]   = go_in[gi] && !pending_q[gi] && !grant_q[gi];
            assign issue_clr[gi] = (state_q == ST_ISSUE) && grant_q[gi];
            assign pending_d[gi] = capture[gi] || (pending_q[gi] && !issue_clr[gi]);

            assign avail_out[gi] = busy && grant_q[gi] && mem_user_available_i;
            assign data_out[gi]  = (busy && grant_q[gi]) ? mem_user_data_i : '0;
            assign done_out[gi]  = (state_q == ST_DONE) && grant_q[gi];
        end
    endgenerate

    assign req0_control_done_o   = done_out[0];
    assign req0_user_available_o = avail_out[0];
    assign req0_user_data_o      = data_out[0];
    assign req1_control_done_o   = done_out[1];
    assign req1_user_available_o = avail_out[1];
    assign req1_user_data_o      = data_out[1];

    assign mem_control_go_o     = (state_q == ST_ISSUE);
    assign mem_control_base_o   = mem_base_q;
    assign mem_control_length_o = mem_len_q;
    assign mem_user_re_o        = busy && |(grant_q & re_in);
    assign grant_o              = grant_q;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        word_cnt_d  = word_cnt_q;
        expected_d  = expected_q;
        done_seen_d = done_seen_q;
        mem_base_d  = mem_base_q;
        mem_len_d   = mem_len_q;
        pick        = 1'b0;
        pop         = mem_user_re_o && mem_user_available_i;
        cnt_next    = word_cnt_q + ADDR_WIDTH'(pop);
        done_now    = done_seen_q || mem_control_done_i;

        case (state_q)
            ST_IDLE: begin
                if (pending_q != 2'b00) begin
                    if (pending_q == 2'b11) begin
                        pick = (ARB_MODE == 1) ? 1'b0 : rr_ptr_q;
                    end else begin
                        pick = pending_q[1];
                    end
                    grant_d     = pick ? 2'b10 : 2'b01;
                    word_cnt_d  = '0;
                    done_seen_d = 1'b0;
                    expected_d  = len_q[pick] / WORD_BYTES_W;
                    mem_base_d  = base_q[pick];
                    mem_len_d   = len_q[pick];
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_BUSY;
            end
            ST_BUSY: begin
                word_cnt_d  = cnt_next;
                done_seen_d = done_now;
                // Release only once downstream is finished and every word has been popped.
                if (done_now && (cnt_next == expected_q)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                rr_ptr_d = grant_q[0];
                grant_d  = 2'b00;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pending_q   <= 2'b00;
            rr_ptr_q    <= 1'b0;
            grant_q     <= 2'b00;
            word_cnt_q  <= '0;
            expected_q  <= '0;
            done_seen_q <= 1'b0;
            mem_base_q  <= '0;
            mem_len_q   <= '0;
            for (int i = 0; i < 2; i++) begin
                base_q[i] <= '0;
                len_q[i]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            word_cnt_q  <= word_cnt_d;
            expected_q  <= expected_d;
            done_seen_q <= done_seen_d;
            mem_base_q  <= mem_base_d;
            mem_len_q   <= mem_len_d;
            for (int i = 0; i < 2; i++) begin
                if (capture[i]) begin
                    base_q[i] <= base_in[i];
                    len_q[i]  <= len_in[i];
                end
            end
        end
    end

endmodule
